// File: rtl/irq_ctrl_pkg.sv
// Shared constants and state encoding for the 16-source interrupt controller.
package irq_ctrl_pkg;

  localparam int N_SRC = 16;
  localparam int ID_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the highest-numbered set request wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) idx = ID_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge detect, pending latch, enable mask, priority
// selection and a req/ack/eoi handshake to the CPU with no nesting.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  output logic [N_SRC-1:0] enable,
  output logic [N_SRC-1:0] pending,
  output logic             cpu_irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic             in_service
);

  state_t           state;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] irq_rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  sel;
  logic             any;

  assign irq_rise = irq_in & ~irq_q;
  assign eligible = pending & enable;

  irq_prio_enc u_prio (
    .req (eligible),
    .idx (sel),
    .any (any)
  );

  // The ack consumes the ID registered at the start of the cycle.
  always_comb begin
    clr = '0;
    if (state == REQ && cpu_ack) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values, independent of block order.
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
      enable  <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= irq_rise | (pending & ~clr);
      if (en_we) enable <= en_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_irq    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            irq_id  <= sel;
            cpu_irq <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (cpu_ack) begin
            cpu_irq    <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end else if (!any) begin
            cpu_irq <= 1'b0;
            state   <= IDLE;
          end else begin
            irq_id <= sel;
          end
        end
        SERVICE: begin
          if (cpu_eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a flag-based behavioural model.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_in;
  logic        en_we;
  logic [15:0] en_wdata;
  logic [15:0] enable;
  logic [15:0] pending;
  logic        cpu_irq;
  logic [3:0]  irq_id;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        in_service;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_prev_in, m_pend, m_en;
  bit          m_requesting, m_servicing;
  int          m_id;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .enable     (enable),
    .pending    (pending),
    .cpu_irq    (cpu_irq),
    .irq_id     (irq_id),
    .cpu_ack    (cpu_ack),
    .cpu_eoi    (cpu_eoi),
    .in_service (in_service)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [15:0] v);
    for (int b = 15; b >= 0; b--) if (v[b]) return b;
    return -1;
  endfunction

  task automatic model_step();
    logic [15:0] rises, elig, cleared;
    int          best;
    rises   = irq_in & ~m_prev_in;
    elig    = m_pend & m_en;
    best    = top_bit(elig);
    cleared = 16'h0000;
    if (rst) begin
      m_prev_in = '0; m_pend = '0; m_en = '0;
      m_requesting = 0; m_servicing = 0; m_id = 0;
      return;
    end
    if (m_requesting) begin
      if (cpu_ack) begin
        cleared = 16'h0001 << m_id;
        m_requesting = 0;
        m_servicing  = 1;
      end else if (best < 0) begin
        m_requesting = 0;
      end else begin
        m_id = best;
      end
    end else if (m_servicing) begin
      if (cpu_eoi) m_servicing = 0;
    end else if (best >= 0) begin
      m_id = best;
      m_requesting = 1;
    end
    m_pend    = rises | (m_pend & ~cleared);
    if (en_we) m_en = en_wdata;
    m_prev_in = irq_in;
  endtask

  // One clock: model and DUT advance together, outputs compared 1 ns later,
  // then single-cycle pulses are dropped.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("enable",     32'(enable),     32'(m_en));
    check("pending",    32'(pending),    32'(m_pend));
    check("cpu_irq",    32'(cpu_irq),    32'(m_requesting));
    check("irq_id",     32'(irq_id),     32'(m_id));
    check("in_service", 32'(in_service), 32'(m_servicing));
    rst = 0; en_we = 0; cpu_ack = 0; cpu_eoi = 0;
  endtask

  task automatic write_en(input logic [15:0] v);
    en_we = 1; en_wdata = v;
    tick();
  endtask

  task automatic pulse(input logic [15:0] lines);
    irq_in = lines; tick();
    irq_in = '0;    tick();
  endtask

  initial begin
    rst = 1; irq_in = '0; en_we = 0; en_wdata = '0; cpu_ack = 0; cpu_eoi = 0;
    m_prev_in = '0; m_pend = '0; m_en = '0; m_requesting = 0; m_servicing = 0; m_id = 0;
    tick();
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_cpu_irq", 32'(cpu_irq), 32'h0);

    // Masked source latches but does not request until enabled.
    pulse(16'h0008);
    check("s1_pend", 32'(pending), 32'h0008);
    tick();
    check("s1_noirq", 32'(cpu_irq), 32'h0);
    write_en(16'h0008);
    tick();
    check("s1_irq", 32'(cpu_irq), 32'h1);
    check("s1_id", 32'(irq_id), 32'd3);
    cpu_ack = 1; tick();
    cpu_eoi = 1; tick();

    // Simultaneous sources: highest first, then the lower one after eoi.
    write_en(16'hFFFF);
    pulse(16'h0204);
    check("s2_id9", 32'(irq_id), 32'd9);
    cpu_ack = 1; tick();
    check("s2_pend", 32'(pending), 32'h0004);
    tick();
    cpu_eoi = 1; tick();
    check("s2_eoi_noirq", 32'(cpu_irq), 32'h0);
    tick();
    check("s2_irq", 32'(cpu_irq), 32'h1);
    check("s2_id2", 32'(irq_id), 32'd2);
    check("s2_pend2", 32'(pending), 32'h0004);
    cpu_ack = 1; tick();
    check("s2_pend0", 32'(pending), 32'h0000);
    cpu_eoi = 1; tick();

    // Higher-priority arrival replaces a request before the ack.
    pulse(16'h0010);
    check("s3_id4", 32'(irq_id), 32'd4);
    pulse(16'h1000);
    check("s3_id12", 32'(irq_id), 32'd12);
    cpu_ack = 1; tick();
    check("s3_pend", 32'(pending), 32'h0010);
    cpu_eoi = 1; tick();
    tick();
    check("s3_again4", 32'(irq_id), 32'd4);
    cpu_ack = 1; tick();
    cpu_eoi = 1; tick();

    // Set wins over clear when the same source re-fires on its ack.
    pulse(16'h0020);
    irq_in = 16'h0020; cpu_ack = 1; tick();
    irq_in = '0;
    check("s4_pend5", 32'(pending), 32'h0020);
    cpu_eoi = 1; tick();
    tick();
    check("s4_irq", 32'(cpu_irq), 32'h1);
    check("s4_id5", 32'(irq_id), 32'd5);
    cpu_ack = 1; tick();
    cpu_eoi = 1; tick();

    // Request withdrawn by masking, then ack racing an enable clear.
    write_en(16'h0080);
    pulse(16'h0080);
    write_en(16'h0000);
    tick();
    check("s5_drop", 32'(cpu_irq), 32'h0);
    check("s5_keep", 32'(pending), 32'h0080);
    write_en(16'h0080);
    tick();
    en_we = 1; en_wdata = 16'h0000; cpu_ack = 1; tick();
    check("s5_ackwins", 32'(in_service), 32'h1);
    cpu_eoi = 1; tick();

    // Reset while in service with work pending.
    write_en(16'hFFFF);
    pulse(16'h8001);
    cpu_ack = 1; tick();
    pulse(16'h8000);
    check("s6_pend", 32'(pending), 32'h8001);
    rst = 1; tick();
    check("s6_rst_pend", 32'(pending), 32'h0);
    check("s6_rst_svc", 32'(in_service), 32'h0);
    cpu_eoi = 1; tick();
    check("s6_eoi_noop", 32'(pending | 16'(cpu_irq) | 16'(in_service)), 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      irq_in   = 16'($urandom & $urandom & $urandom);
      en_we    = ($urandom_range(15) == 0);
      en_wdata = 16'($urandom);
      cpu_ack  = m_requesting ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      cpu_eoi  = m_servicing  ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
      rst      = ($urandom_range(499) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- 16-source interrupt controller for the CPU.
- Edge-detects external request lines, latches them as pending, masks them with a software-writable enable register, and selects the highest-numbered eligible source.
- Presents the selected source to the CPU core through a request/acknowledge/end-of-interrupt handshake.
- No nesting: one interrupt is in service at a time.

Parameters:
- N_SRC, 16, number of interrupt sources (fixed at 16 for this CPU; width checks assume it).
- ID_W, 4, width of the source ID, equal to log2(N_SRC).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  16  raw interrupt lines from peripherals; active-high, rising edge is significant.
- en_we  input  1  write strobe for the enable register.
- en_wdata  input  16  enable register write data; bit i = 1 enables source i.
- enable  output  16  current enable register.
- pending  output  16  current pending register.
- cpu_irq  output  1  interrupt request to the CPU, registered.
- irq_id  output  4  ID of the requested or in-service source, registered.
- cpu_ack  input  1  CPU accepts the interrupt; one-cycle pulse.
- cpu_eoi  input  1  CPU finished the handler; one-cycle pulse.
- in_service  output  1  high while a handler is running.

Behaviour:
- Reset values: enable=0, pending=0, cpu_irq=0, irq_id=0, in_service=0, state=IDLE, irq_q=0.
- Because irq_q resets to 0, a line held high through reset produces an edge on the first cycle after reset.
- Edge detect: edge = irq_in & ~irq_q, where irq_q is irq_in registered each cycle.
- Pending update, per bit i, per cycle: pending[i] <= edge[i] | (pending[i] & ~clr[i]).
  - clr has exactly one bit set on the ack cycle, at index irq_id.
  - Set wins over clear on the same bit in the same cycle.
- Enable: when en_we=1, enable <= en_wdata (takes effect next cycle). Masking never clears pending bits.
- Selection: eligible = pending & enable.
  - sel = index of the highest set bit of eligible (bit 15 has highest priority).
  - any = |eligible.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If any: irq_id <= sel, cpu_irq <= 1, go to REQ.
  - cpu_ack and cpu_eoi are ignored.
- REQ:
  - If cpu_ack: clear pending[irq_id], cpu_irq <= 0, in_service <= 1, go to SERVICE. irq_id is frozen.
  - Else if !any (masked away): cpu_irq <= 0, go to IDLE. irq_id keeps its last value.
  - Else: irq_id <= sel each cycle, so a higher-priority arrival before the ack replaces the request.
  - cpu_ack is acted on using the irq_id value registered at the start of that cycle.
- SERVICE:
  - cpu_irq stays 0; edges continue to set pending bits, including the bit of the source in service.
  - If cpu_eoi: in_service <= 0, go to IDLE.
  - cpu_ack is ignored.
  - cpu_eoi and a new request take effect on consecutive cycles; a new request never asserts cpu_irq in the eoi cycle itself.
- Latency:
  - irq_in rises before edge t: pending set after t, cpu_irq high after t+1.
  - After eoi at edge t with work pending: cpu_irq high after t+1.
- Simultaneous events:
  - en_we clearing the only eligible bit in the same cycle as cpu_ack: the ack wins (enable is registered; the old enable value is used).
  - Reset mid-operation (any state) returns everything to reset values; a pending handler is lost.

Decomposition:
- Package irq_ctrl_pkg holds:
  - N_SRC and ID_W constants.
  - State enum IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
- One sub-module, irq_prio_enc: combinational 16-to-4 highest-index-wins encoder with an `any` output.
  - Instantiated once on eligible.
  - Also reusable by other arbitration logic in the CPU.

Test Plan:
- Reset, then enable=16'h0000 and irq_in[3] pulses: pending=16'h0008, cpu_irq stays 0. Then enable=16'h0008: cpu_irq=1 and irq_id=3 two cycles later.
- enable=16'hFFFF, irq_in[2] and irq_in[9] rise together: irq_id=9. After ack then eoi: irq_id=2, cpu_irq re-asserts one cycle after eoi, pending=16'h0004 until the second ack.
- In REQ with irq_id=4, irq_in[12] rises before the ack: irq_id becomes 12 one cycle after pending[12] sets. Ack clears bit 12 only, and pending[4] remains.
- irq_in[5] edge in the same cycle as cpu_ack for id 5: pending[5] stays 1, and source 5 is requested again after eoi.
- In REQ with only source 7 pending, write enable=16'h0000: cpu_irq drops next cycle, FSM returns to IDLE, pending[7]=1 is preserved.
- Assert rst while in SERVICE with pending=16'h8001: all outputs return to reset values. A spurious cpu_eoi after reset changes nothing.
